// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-bit multiply/divide sequencer beside the EX stage.
// Owns the HI/LO pair, runs a 32-step shift-add multiply or restoring divide,
// stalls the front of the pipeline while busy, and services MTHI/MTLO writes.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  input  logic        hi_write_en,
  input  logic        lo_write_en,
  input  logic [31:0] hilo_write_data,
  output logic        stall_request,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_reg;
  logic [4:0]  count_reg;
  logic [63:0] mcand_reg;    // multiplicand magnitude, shifted left each step
  logic [31:0] shift_reg;    // multiplier (MUL) or dividend turning into quotient (DIV)
  logic [31:0] divisor_reg;
  logic [63:0] acc_reg;      // product accumulator
  logic [31:0] rem_reg;      // remainder is always below the divisor, so 32 bits hold it
  logic        neg_q_reg;    // negate product / quotient at the end
  logic        neg_r_reg;    // negate remainder at the end
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  // Operand decode: MULT/DIV work on magnitudes, MULTU/DIVU on raw values.
  logic        is_signed;
  logic        is_div;
  logic        sign_1;
  logic        sign_2;
  logic [31:0] mag_1;
  logic [31:0] mag_2;

  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign sign_1    = is_signed & operand_1[31];
  assign sign_2    = is_signed & operand_2[31];
  assign mag_1     = sign_1 ? (32'd0 - operand_1) : operand_1;
  assign mag_2     = sign_2 ? (32'd0 - operand_2) : operand_2;

  // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
  logic [63:0] acc_step;
  logic [63:0] product;

  assign acc_step = acc_reg + (shift_reg[0] ? mcand_reg : 64'd0);
  assign product  = neg_q_reg ? (64'd0 - acc_step) : acc_step;

  // One restoring divide step on the 33-bit partial remainder.
  logic [32:0] rem_shift;
  logic        q_bit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quotient;
  logic [31:0] remainder;

  assign rem_shift = {rem_reg, shift_reg[31]};
  assign q_bit     = (rem_shift >= {1'b0, divisor_reg});
  // When q_bit is set the true difference is below the divisor, so 32 bits are exact.
  assign rem_step  = q_bit ? (rem_shift[31:0] - divisor_reg) : rem_shift[31:0];
  assign quo_step  = {shift_reg[30:0], q_bit};
  assign quotient  = neg_q_reg ? (32'd0 - quo_step) : quo_step;
  assign remainder = neg_r_reg ? (32'd0 - rem_step) : rem_step;

  logic last_iter;
  assign last_iter = (count_reg == 5'd31);

  // Stall while an op is being accepted or iterating; never during reset.
  assign stall_request = ~rst & (((state_reg == IDLE) & start & ~flush) |
                                 (state_reg == MUL) | (state_reg == DIV));

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  // Sequencer: accepts ops, iterates, writes HI/LO, and handles MT writes and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= 5'd0;
      mcand_reg   <= 64'd0;
      shift_reg   <= 32'd0;
      divisor_reg <= 32'd0;
      acc_reg     <= 64'd0;
      rem_reg     <= 32'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      // MT writes only while the pipeline is not frozen; a result written on the
      // same edge (divide by zero) is assigned later and therefore wins.
      if ((state_reg == IDLE) || (state_reg == DONE)) begin
        if (hi_write_en) hi_reg <= hilo_write_data;
        if (lo_write_en) lo_reg <= hilo_write_data;
      end

      if (flush) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              count_reg   <= 5'd0;
              acc_reg     <= 64'd0;
              rem_reg     <= 32'd0;
              neg_q_reg   <= sign_1 ^ sign_2;
              neg_r_reg   <= sign_1;
              mcand_reg   <= {32'd0, mag_1};
              shift_reg   <= is_div ? mag_1 : mag_2;
              divisor_reg <= mag_2;
              if (is_div && (operand_2 == 32'd0)) begin
                hi_reg    <= operand_1;
                lo_reg    <= 32'hFFFF_FFFF;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                state_reg <= is_div ? DIV : MUL;
              end
            end
          end
          MUL: begin
            acc_reg   <= acc_step;
            mcand_reg <= mcand_reg << 1;
            shift_reg <= shift_reg >> 1;
            count_reg <= count_reg + 5'd1;
            if (last_iter) begin
              hi_reg    <= product[63:32];
              lo_reg    <= product[31:0];
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
          DIV: begin
            rem_reg   <= rem_step;
            shift_reg <= quo_step;
            count_reg <= count_reg + 5'd1;
            if (last_iter) begin
              hi_reg    <= remainder;
              lo_reg    <= quotient;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
          DONE: begin
            state_reg <= IDLE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer that sits beside the EX stage and owns the HI/LO register pair. EX hands it a MULT/MULTU/DIV/DIVU operation with two 32-bit operands. The block then runs a 32-iteration shift-add multiply or restoring divide and holds the pipeline with a stall request until the result is written to HI/LO. It also services MTHI/MTLO writes and aborts cleanly on a pipeline flush.

## Interface
Parameters:
- none. Iteration count is fixed at 32.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: EX presents a mul/div op this cycle.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `operand_1` in 32: multiplicand / dividend (rs).
- `operand_2` in 32: multiplier / divisor (rt).
- `flush` in 1: abort any operation in progress.
- `hi_write_en` in 1: MTHI.
- `lo_write_en` in 1: MTLO.
- `hilo_write_data` in 32: data for MTHI/MTLO.
- `stall_request` out 1: combinational; freezes IF/ID/EX.
- `done` out 1: registered; one-cycle pulse when HI/LO take a new result.
- `hi` out 32: registered HI.
- `lo` out 32: registered LO.

## Operation
- States: IDLE, MUL, DIV, DONE. Iteration counter is 5 bits.
- IDLE, `start`=1, `flush`=0:
  - Latch |operand_1| and |operand_2|. Magnitudes apply for MULT/DIV only; MULTU/DIVU take raw values.
  - Latch result-sign flags: product/quotient sign = s1^s2; remainder sign = s1. Both are 0 for unsigned ops.
  - Clear counter. Go to MUL or DIV.
- DIVU/DIV with `operand_2`==0: go directly to DONE and write lo=32'hFFFFFFFF, hi=operand_1 (raw).
- MUL: radix-2 shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV: restoring division, one quotient bit per cycle, MSB first. Partial remainder is 33 bits.
- On the edge that completes iteration 31:
  - Apply the sign fix by two's-complement negation. The product is negated as 64 bits; quotient and remainder are negated independently.
  - Write hi = product[63:32] / remainder and lo = product[31:0] / quotient.
  - Go to DONE.
- Overflow case: DIV 0x80000000 / -1 produces quotient 0x80000000, remainder 0. This falls out of the magnitude arithmetic; no special case.
- DONE: `done`=1 and `stall_request`=0 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- `stall_request` = (state==IDLE & start & ~flush) | state==MUL | state==DIV. It is forced to 0 while `rst`=1.
- `flush` (any state): next state is IDLE. No HI/LO write, no `done`. Flush has priority over `start` and over iteration completion.
- MTHI/MTLO:
  - Honored only in IDLE or DONE.
  - Ignored in MUL/DIV, because the pipeline is stalled.
  - If an MT write coincides with `start` in IDLE, the write is applied and the op still starts; the later result overwrites it.
- Reset: state IDLE, counter 0, hi=0, lo=0, `done`=0, sign flags 0. Reset mid-operation discards all progress.

## Timing
- Normal op: `start` sampled at cycle 0.
  - Cycles 1–32 are iterations.
  - HI/LO are written at the edge ending cycle 32.
  - `done`=1 and new hi/lo are visible in cycle 33.
  - `stall_request` is high in cycles 0–32 (33 cycles).
- Divide by zero: `stall_request` high in cycle 0 only; `done` and new hi/lo in cycle 1.
- Flush asserted in cycle k, with 1≤k≤32: `stall_request` drops in cycle k+1, state is IDLE, hi/lo are unchanged.
- MT write sampled at edge n: new value visible on hi/lo in cycle n+1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → cycle 33: `done`=1, hi=0xFFFFFFFE, lo=0x00000001; `stall_request` high exactly cycles 0–32.
- MULT −3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 100 / 0 → cycle 1: `done`=1, lo=0xFFFFFFFF, hi=0x00000064; stall high only in cycle 0.
- Preload hi/lo=0x11111111/0x22222222 via MTHI/MTLO, start MULTU 5×6, flush at cycle 10 → no `done`, stall low from cycle 11, hi/lo unchanged. Then restart the op → hi=0, lo=30 at 33 cycles after the restart.
- Assert `rst` at cycle 15 of a DIV → next cycle hi=lo=0, `done`=0, `stall_request`=0. MTLO issued during MUL is ignored; MTLO in the DONE cycle takes effect.
